capp_sequencer: RTL and testbench

CAPP_SEQUENCER -- requirements
Module: capp_sequencer

---
 rtl/capp_sequencer.sv | 114 +++++++++++
 tb/tb_capp_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/capp_sequencer.sv
// Command sequencer for a CAM-style cell array: drives match/write line pairs, waits for them to settle,
// then samples tags/read_lines into a held response. Optional hit statistics via `CAPP_SEQ_STATS_EN.
module capp_sequencer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_key,
    input  logic [31:0] cmd_mask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_tags,
    output logic [2:0]  resp_count,
    output logic        resp_any,
    output logic [63:0] match_lines,
    output logic [63:0] write_lines,
    input  logic [4:0]  tags,
    input  logic [31:0] read_lines
`ifdef CAPP_SEQ_STATS_EN
    ,
    output logic [15:0] hit_count
`endif
);

    localparam logic [1:0] OP_SEARCH = 2'd0;
    localparam logic [1:0] OP_WRITE  = 2'd1;
    localparam logic [1:0] OP_READ   = 2'd2;

    typedef enum logic [2:0] {IDLE, DRIVE, WRITE, SAMPLE, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [1:0]  op_q;
    logic [31:0] key_q, mask_q;

    // Pair j: [2j] selects stored 1, [2j+1] selects stored 0; a masked bit drives neither.
    function automatic logic [63:0] pairs(input logic [31:0] k, input logic [31:0] m);
        logic [63:0] p;
        p = '0;
        for (int j = 0; j < 32; j++) begin
            p[2*j]   = k[j] & m[j];
            p[2*j+1] = ~k[j] & m[j];
        end
        return p;
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE:   if (cmd_valid) begin
                        state_nx = DRIVE;
                        cnt_nx   = 4'(SETTLE);
                    end
            DRIVE:  if (cnt == 4'd0) state_nx = (op_q == OP_WRITE) ? WRITE : SAMPLE;
                    else             cnt_nx   = cnt - 4'd1;
            WRITE:  state_nx = SAMPLE;
            SAMPLE: state_nx = RESP;
            RESP:   if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= '0;
            key_q       <= '0;
            mask_q      <= '0;
            match_lines <= '0;
            resp_data   <= '0;
            resp_tags   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && cmd_valid) begin
                op_q   <= cmd_op;
                key_q  <= cmd_key;
                mask_q <= cmd_mask;
                // Search pattern goes out straight from the accepted command and persists afterwards.
                if (cmd_op == OP_SEARCH) match_lines <= pairs(cmd_key, cmd_mask);
            end
            if (state == SAMPLE) begin
                resp_tags <= tags;
                resp_data <= (op_q == OP_READ) ? read_lines : 32'd0;
            end
        end
    end

`ifdef CAPP_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hit_count <= '0;
        else if (state == SAMPLE && op_q == OP_SEARCH && (|tags) && hit_count != 16'hFFFF)
            hit_count <= hit_count + 16'd1;
    end
`endif

    always_comb begin
        resp_count = '0;
        for (int i = 0; i < 5; i++) resp_count = resp_count + {2'b00, resp_tags[i]};
    end

    assign resp_any    = |resp_tags;
    assign cmd_ready   = (state == IDLE);
    assign resp_valid  = (state == RESP);
    assign write_lines = (state == WRITE) ? pairs(key_q, mask_q) : 64'd0;

endmodule

// File: tb/tb_capp_sequencer.sv
// Self-checking bench for capp_sequencer: directed vector table, hand-written corner sequences,
// and randomized commands checked against a behavioural model of line patterns and latency.
module tb_capp_sequencer;

    localparam int SETTLE = 1;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        cmd_valid = 0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 0;
    logic [31:0] cmd_key = 0, cmd_mask = 0;
    logic        resp_valid;
    logic        resp_ready = 0;
    logic [31:0] resp_data;
    logic [4:0]  resp_tags;
    logic [2:0]  resp_count;
    logic        resp_any;
    logic [63:0] match_lines, write_lines;
    logic [4:0]  tags = 0;
    logic [31:0] read_lines = 0;
`ifdef CAPP_SEQ_STATS_EN
    logic [15:0] hit_count;
`endif

    capp_sequencer #(.SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_key(cmd_key), .cmd_mask(cmd_mask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tags(resp_tags), .resp_count(resp_count), .resp_any(resp_any),
        .match_lines(match_lines), .write_lines(write_lines),
        .tags(tags), .read_lines(read_lines)
`ifdef CAPP_SEQ_STATS_EN
        , .hit_count(hit_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A line pair may never select both stored values at once.
    always @(negedge clk) if (rst_n) begin
        logic bad;
        bad = 0;
        for (int j = 0; j < 32; j++)
            if ((match_lines[2*j] & match_lines[2*j+1]) || (write_lines[2*j] & write_lines[2*j+1])) bad = 1;
        chk("pair_exclusive", {63'd0, bad}, 64'd0);
    end

    // Reference: for every enabled bit, raise the "stored 1" wire if key bit is 1, else the "stored 0" wire.
    function automatic logic [63:0] ref_lines(input logic [31:0] k, input logic [31:0] m);
        logic [63:0] r;
        r = 0;
        for (int j = 0; j < 32; j++)
            if (m[j]) r = r | (64'd1 << (2 * j + (k[j] ? 0 : 1)));
        return r;
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [31:0] key, mask;
        logic [4:0]  tg;
        logic [31:0] rl;
        logic [63:0] exp_match, exp_write;
        logic [31:0] exp_data;
        logic [2:0]  exp_count;
        logic        exp_any;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    // Outputs observed by run_cmd
    int          o_lat, o_wr_cnt;
    logic [63:0] o_wr_seen, o_match;
    logic [63:0] model_match;
    int          model_hits;

    // Issue one command, record match_lines after acceptance, write pulses and response latency.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] key, input logic [31:0] mask,
                           input logic [4:0] tg, input logic [31:0] rl, input string nm);
        @(negedge clk);
        tags = tg; read_lines = rl;
        cmd_op = op; cmd_key = key; cmd_mask = mask; cmd_valid = 1; resp_ready = 0;
        chk({nm, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
        @(posedge clk); #1;
        cmd_valid = 0;
        cmd_key = $urandom; cmd_mask = $urandom; cmd_op = 2'($urandom);
        o_match = match_lines; o_wr_cnt = 0; o_wr_seen = 0; o_lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (write_lines != 0) begin o_wr_cnt++; o_wr_seen = write_lines; end
            if (resp_valid) begin o_lat = c; break; end
        end
        chk({nm, "_resp_seen"}, {63'd0, o_lat > 0}, 64'd1);
    endtask

    task automatic finish_resp();
        @(negedge clk); resp_ready = 1;
        @(negedge clk); resp_ready = 0;
    endtask

    task automatic check_vec(input vec_t v, input string nm);
        run_cmd(v.op, v.key, v.mask, v.tg, v.rl, nm);
        chk({nm, "_match"}, o_match, v.exp_match);
        chk({nm, "_write"}, o_wr_seen, v.exp_write);
        chk({nm, "_wr_pulses"}, 64'(o_wr_cnt), (v.op == 2'd1) ? 64'd1 : 64'd0);
        chk({nm, "_lat"}, 64'(o_lat), 64'(v.exp_lat));
        chk({nm, "_tags"}, 64'(resp_tags), 64'(v.tg));
        chk({nm, "_data"}, 64'(resp_data), 64'(v.exp_data));
        chk({nm, "_count"}, 64'(resp_count), 64'(v.exp_count));
        chk({nm, "_any"}, 64'(resp_any), 64'(v.exp_any));
        finish_resp();
    endtask

    initial begin
        logic [63:0] snap_match;
        logic [31:0] snap_data;
        logic [4:0]  snap_tags;
        int          acc_cyc;

        vecs[0] = '{2'd0, 32'h0000_00A5, 32'h0000_00FF, 5'b01101, 32'h1234_5678,
                    64'h0000_0000_0000_6699, 64'd0, 32'd0, 3'd3, 1'b1, SETTLE + 2};
        vecs[1] = '{2'd1, 32'hFFFF_0000, 32'hFFFF_FFFF, 5'b00000, 32'h0,
                    64'h0000_0000_0000_6699, 64'h5555_5555_AAAA_AAAA, 32'd0, 3'd0, 1'b0, SETTLE + 3};
        vecs[2] = '{2'd2, 32'h0, 32'h0, 5'b10110, 32'hDEAD_BEEF,
                    64'h0000_0000_0000_6699, 64'd0, 32'hDEAD_BEEF, 3'd3, 1'b1, SETTLE + 2};
        vecs[3] = '{2'd0, 32'hFFFF_FFFF, 32'h0, 5'b11111, 32'hFFFF_FFFF,
                    64'd0, 64'd0, 32'd0, 3'd5, 1'b1, SETTLE + 2};
        vecs[4] = '{2'd3, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 5'b00001, 32'hCAFE_F00D,
                    64'd0, 64'd0, 32'd0, 3'd1, 1'b1, SETTLE + 2};

        // Reset state
        #12; #1;
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_match", match_lines, 64'd0);
        chk("rst_write", write_lines, 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_resp_tags", 64'(resp_tags), 64'd0);
        chk("rst_resp_count", 64'(resp_count), 64'd0);
        chk("rst_resp_any", 64'(resp_any), 64'd0);
        @(negedge clk); rst_n = 1;
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // WRITE and READ before any SEARCH see match_lines all zero
        run_cmd(2'd1, 32'h1234_5678, 32'hFFFF_FFFF, 5'd0, 32'd0, "early_write");
        chk("early_write_match", o_match, 64'd0);
        finish_resp();
        run_cmd(2'd2, 32'd0, 32'd0, 5'd2, 32'h0BAD_F00D, "early_read");
        chk("early_read_match", o_match, 64'd0);
        chk("early_read_data", 64'(resp_data), 64'h0BAD_F00D);
        finish_resp();

        for (int i = 0; i < 5; i++) check_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-pressure: response held, cmd_valid ignored, next accept only after handshake
        run_cmd(2'd2, 32'd0, 32'd0, 5'b10101, 32'h5A5A_A5A5, "hold");
        snap_data = resp_data; snap_tags = resp_tags; snap_match = match_lines;
        @(negedge clk);
        cmd_valid = 1; cmd_op = 2'd0; cmd_key = 32'hFFFF_FFFF; cmd_mask = 32'hFFFF_FFFF;
        tags = 5'd0; read_lines = 32'd0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, resp_valid}, 64'd1);
            chk("hold_ready", {63'd0, cmd_ready}, 64'd0);
            chk("hold_data", 64'(resp_data), 64'(snap_data));
            chk("hold_tags", 64'(resp_tags), 64'(snap_tags));
            chk("hold_match", match_lines, snap_match);
        end
        resp_ready = 1;
        @(negedge clk); resp_ready = 0;
        chk("hold_after_hs_ready", {63'd0, cmd_ready}, 64'd1);
        chk("hold_not_yet_accepted", match_lines, snap_match);
        acc_cyc = 0;
        while (cmd_ready && acc_cyc < 5) begin @(negedge clk); acc_cyc++; end
        cmd_valid = 0;
        chk("hold_second_accept", match_lines, ref_lines(32'hFFFF_FFFF, 32'hFFFF_FFFF));
        while (!resp_valid && acc_cyc < 20) begin @(negedge clk); acc_cyc++; end
        chk("hold_second_resp", {63'd0, resp_valid}, 64'd1);
        finish_resp();

        // Reset during WRITE: lines drop at once, no response, ready after release
        @(negedge clk);
        cmd_op = 2'd1; cmd_key = 32'hFFFF_0000; cmd_mask = 32'hFFFF_FFFF; cmd_valid = 1;
        @(posedge clk); #1 cmd_valid = 0;
        acc_cyc = 0;
        while (write_lines == 0 && acc_cyc < 20) begin @(posedge clk); #1; acc_cyc++; end
        chk("rstw_in_write", {63'd0, write_lines != 0}, 64'd1);
        #2 rst_n = 0; #1;
        chk("rstw_write", write_lines, 64'd0);
        chk("rstw_match", match_lines, 64'd0);
        chk("rstw_valid", {63'd0, resp_valid}, 64'd0);
        @(negedge clk); rst_n = 1;
        chk("rstw_ready", {63'd0, cmd_ready}, 64'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rstw_no_resp", {63'd0, resp_valid | (write_lines != 0)}, 64'd0);
        end

        // Randomized commands against the behavioural model
        model_match = 0; model_hits = 0;
        for (int n = 0; n < 60; n++) begin
            logic [1:0] op; logic [31:0] k, m, rl; logic [4:0] tg;
            op = 2'($urandom_range(0, 3));
            k = $urandom; m = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            tg = 5'($urandom); rl = $urandom;
            run_cmd(op, k, m, tg, rl, "rnd");
            if (op == 2'd0) begin
                model_match = ref_lines(k, m);
                if (tg != 0) model_hits++;
            end
            chk("rnd_match", o_match, model_match);
            chk("rnd_write", o_wr_seen, (op == 2'd1) ? ref_lines(k, m) : 64'd0);
            chk("rnd_lat", 64'(o_lat), 64'(SETTLE + 2 + ((op == 2'd1) ? 1 : 0)));
            chk("rnd_tags", 64'(resp_tags), 64'(tg));
            chk("rnd_data", 64'(resp_data), (op == 2'd2) ? 64'(rl) : 64'd0);
            chk("rnd_count", 64'(resp_count), 64'($countones(tg)));
            chk("rnd_any", 64'(resp_any), 64'(tg != 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            finish_resp();
        end

`ifdef CAPP_SEQ_STATS_EN
        chk("hit_count_model", 64'(hit_count), 64'(model_hits));
        @(negedge clk); rst_n = 0; @(negedge clk); rst_n = 1;
        chk("hit_count_rst", 64'(hit_count), 64'd0);
        run_cmd(2'd0, 32'h1, 32'h1, 5'b00001, 32'd0, "hs1"); finish_resp();
        run_cmd(2'd0, 32'h2, 32'h3, 5'b00001, 32'd0, "hs2"); finish_resp();
        run_cmd(2'd0, 32'h3, 32'h3, 5'b00000, 32'd0, "hs3"); finish_resp();
        run_cmd(2'd0, 32'h4, 32'h7, 5'b00001, 32'd0, "hs4"); finish_resp();
        chk("hit_count_three", 64'(hit_count), 64'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
